// File: rtl/ahblite_apb_bridge_if.sv
// rtl/ahblite_apb_bridge_if.sv - AHB-Lite slave lane and APB4 master signal bundle for the bridge
interface ahblite_apb_bridge_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // Bridge side: AHB-Lite slave, APB requester
    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ahblite_apb_bridge.sv
// rtl/ahblite_apb_bridge.sv - single-transfer AHB-Lite to APB4 bridge with wait and error mapping
module ahblite_apb_bridge #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahblite_apb_bridge_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic [31:0]           rdata_q, rdata_d;

    logic       accept;
    logic       in_xfer;
    logic [3:0] strb;
    logic       unused_bits;

    assign accept      = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign unused_bits = ^{bus.HADDR, bus.HSIZE, bus.HTRANS};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        case (state_q)
            // Only cycles with HREADYOUT=1 can complete an address phase
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) begin
                    state_d = S_SETUP;
                    addr_d  = bus.HADDR[ADDR_WIDTH-1:0];
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE[1:0];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (bus.PREADY) begin
                    if (bus.PSLVERR) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_DONE;
                        if (!write_q) rdata_d = bus.PRDATA;
                    end
                end
            end
            S_ERR1:   state_d = S_ERR2;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        strb = 4'b1111;
        case (size_q)
            2'd0:    strb = 4'b0001 << addr_q[1:0];
            2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    assign in_xfer = (state_q == S_SETUP) || (state_q == S_ACCESS);

    assign bus.HREADYOUT = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.HRDATA    = rdata_q;
    assign bus.PADDR     = addr_q;
    assign bus.PSEL      = in_xfer;
    assign bus.PENABLE   = (state_q == S_ACCESS);
    assign bus.PWRITE    = write_q;
    // The master holds HWDATA while HREADYOUT is low, so it can feed PWDATA directly
    assign bus.PWDATA    = in_xfer ? bus.HWDATA : 32'd0;
    assign bus.PSTRB     = (in_xfer && write_q) ? strb : 4'b0000;
endmodule

// File: tb/tb_ahblite_apb_bridge.sv
// tb/tb_ahblite_apb_bridge.sv - randomized self-checking bench for ahblite_apb_bridge
module tb_ahblite_apb_bridge;
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        bit          write;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        logic [31:0] rdata;
    } xfer_t;

    logic HCLK;
    logic HRESETn;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_rdata;

    ahblite_apb_bridge_if #(.ADDR_WIDTH(16)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahblite_apb_bridge #(.ADDR_WIDTH(16)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Byte lanes touched by a write: a byte picks lane addr%4, a half picks lanes 0-1 or 2-3
    function automatic logic [3:0] model_strb(input xfer_t t);
        int lane;
        if (!t.write) return 4'b0000;
        lane = int'(t.addr[1:0]);
        case (t.size[1:0])
            2'd0:    return 4'(1 << lane);
            2'd1:    return (lane >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t t;
        t.addr  = $urandom;
        t.size  = 3'($urandom_range(0, 3));
        t.write = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.waits = $urandom_range(0, 4);
        t.err   = ($urandom_range(0, 4) == 0);
        t.rdata = $urandom;
        return t;
    endfunction

    task automatic drive_addr(input xfer_t t);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'($urandom_range(2, 3));
        bus.HADDR  = t.addr;
        bus.HSIZE  = t.size;
        bus.HWRITE = t.write;
        bus.HWDATA = t.wdata;
    endtask

    // Called at a negedge with the address phase already driven and HREADYOUT high
    task automatic do_xfer(input xfer_t t, input bit has_next, input xfer_t tn);
        int dlen    = 3 + t.waits + (t.err ? 1 : 0);
        int acc_end = 1 + t.waits;
        @(posedge HCLK);
        for (int i = 0; i < dlen; i++) begin
            @(negedge HCLK);
            if (i == 0) begin
                bus.HTRANS = 2'b00;
                bus.HSEL   = 1'($urandom_range(0, 1));
            end
            check_eq("hreadyout", 32'(bus.HREADYOUT), 32'(i == dlen - 1));
            check_eq("hresp", 32'(bus.HRESP), 32'(t.err && i >= dlen - 2));
            check_eq("psel", 32'(bus.PSEL), 32'(i <= acc_end));
            check_eq("penable", 32'(bus.PENABLE), 32'(i >= 1 && i <= acc_end));
            if (i <= acc_end) begin
                check_eq("paddr", 32'(bus.PADDR), 32'(t.addr[15:0]));
                check_eq("pwrite", 32'(bus.PWRITE), 32'(t.write));
                check_eq("pstrb", 32'(bus.PSTRB), 32'(model_strb(t)));
                check_eq("pwdata", bus.PWDATA, t.wdata);
            end else begin
                check_eq("pstrb_idle", 32'(bus.PSTRB), 32'd0);
            end
            if (i == acc_end + 1 && !t.write && !t.err) exp_rdata = t.rdata;
            check_eq("hrdata", bus.HRDATA, exp_rdata);
            if (i == acc_end) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = t.err;
                bus.PRDATA  = t.rdata;
            end else begin
                bus.PREADY  = (i == 0 || i > acc_end) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.PSLVERR = 1'($urandom_range(0, 1));
                bus.PRDATA  = $urandom;
            end
        end
        if (has_next) begin
            drive_addr(tn);
        end else begin
            bus.HTRANS = 2'b00;
            bus.HSEL   = 1'b0;
        end
    endtask

    // One cycle of IDLE/BUSY or unselected traffic, which must see a zero-wait OKAY
    task automatic idle_cycle();
        if ($urandom_range(0, 1) == 0) begin
            bus.HSEL   = 1'b0;
            bus.HTRANS = 2'($urandom_range(0, 3));
        end else begin
            bus.HSEL   = 1'b1;
            bus.HTRANS = 2'($urandom_range(0, 1));
        end
        bus.HADDR  = $urandom;
        bus.HWRITE = 1'($urandom_range(0, 1));
        bus.PREADY = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
        @(negedge HCLK);
        check_eq("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check_eq("idle_hresp", 32'(bus.HRESP), 32'd0);
        check_eq("idle_psel", 32'(bus.PSEL), 32'd0);
        check_eq("idle_penable", 32'(bus.PENABLE), 32'd0);
        check_eq("idle_hrdata", bus.HRDATA, exp_rdata);
    endtask

    initial begin
        xfer_t t, t2, cur, nxt;
        bit nb;
        HRESETn     = 1'b0;
        bus.HSEL    = 1'b0;
        bus.HADDR   = 32'd0;
        bus.HTRANS  = 2'b00;
        bus.HSIZE   = 3'd0;
        bus.HWRITE  = 1'b0;
        bus.HWDATA  = 32'd0;
        bus.PRDATA  = 32'd0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        exp_rdata   = 32'd0;

        repeat (3) @(negedge HCLK);
        check_eq("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check_eq("rst_hresp", 32'(bus.HRESP), 32'd0);
        check_eq("rst_hrdata", bus.HRDATA, 32'd0);
        check_eq("rst_psel", 32'(bus.PSEL), 32'd0);
        check_eq("rst_penable", 32'(bus.PENABLE), 32'd0);
        check_eq("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check_eq("rst_paddr", 32'(bus.PADDR), 32'd0);
        check_eq("rst_pstrb", 32'(bus.PSTRB), 32'd0);
        HRESETn = 1'b1;
        repeat (2) idle_cycle();

        t = '{addr: 32'h0000_1234, size: 3'd2, write: 1'b0, wdata: 32'h0,
              waits: 0, err: 1'b0, rdata: 32'hDEAD_BEEF};
        drive_addr(t);
        do_xfer(t, 1'b0, t);
        idle_cycle();

        t = '{addr: 32'h5A5A_0006, size: 3'd0, write: 1'b1, wdata: 32'h00AA_0000,
              waits: 3, err: 1'b0, rdata: 32'h1111_2222};
        drive_addr(t);
        do_xfer(t, 1'b0, t);
        idle_cycle();

        t = '{addr: 32'h0000_0040, size: 3'd2, write: 1'b0, wdata: 32'h0,
              waits: 0, err: 1'b1, rdata: 32'hBAD0_BAD0};
        drive_addr(t);
        do_xfer(t, 1'b0, t);
        idle_cycle();

        t  = '{addr: 32'h0000_2002, size: 3'd1, write: 1'b1, wdata: 32'hCAFE_F00D,
               waits: 1, err: 1'b0, rdata: 32'h0};
        t2 = '{addr: 32'h0000_3008, size: 3'd2, write: 1'b0, wdata: 32'h0,
               waits: 2, err: 1'b0, rdata: 32'h1234_5678};
        drive_addr(t);
        do_xfer(t, 1'b1, t2);
        do_xfer(t2, 1'b0, t2);
        idle_cycle();

        t = '{addr: 32'h0000_0100, size: 3'd2, write: 1'b0, wdata: 32'h0,
              waits: 6, err: 1'b0, rdata: 32'h0};
        drive_addr(t);
        @(posedge HCLK);
        @(negedge HCLK);
        bus.HTRANS = 2'b00;
        bus.HSEL   = 1'b0;
        bus.PREADY = 1'b0;
        @(negedge HCLK);
        check_eq("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        HRESETn = 1'b0;
        #1;
        check_eq("arst_psel", 32'(bus.PSEL), 32'd0);
        check_eq("arst_penable", 32'(bus.PENABLE), 32'd0);
        check_eq("arst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check_eq("arst_hrdata", bus.HRDATA, 32'd0);
        exp_rdata = 32'd0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        idle_cycle();
        t = '{addr: 32'h0000_0104, size: 3'd2, write: 1'b0, wdata: 32'h0,
              waits: 1, err: 1'b0, rdata: 32'h0BAD_F00D};
        drive_addr(t);
        do_xfer(t, 1'b0, t);

        cur = rand_xfer();
        drive_addr(cur);
        for (int n = 0; n < 120; n++) begin
            nb  = 1'($urandom_range(0, 1));
            nxt = rand_xfer();
            do_xfer(cur, nb, nxt);
            if (!nb) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
                drive_addr(nxt);
            end
            cur = nxt;
        end
        do_xfer(cur, 1'b0, cur);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
